// File: rtl/alu_datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_datapath_pkg
// Purpose  : Shared encodings for the ALU datapath: decoded ALU operation
//            codes, main-control operation classes and funct field values.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package alu_datapath_pkg;

  // Decoded ALU operation codes driven onto alu_op.
  typedef enum logic [3:0] {
    c_ALU_AND = 4'b0000,
    c_ALU_OR  = 4'b0001,
    c_ALU_ADD = 4'b0010,
    c_ALU_XOR = 4'b0011,
    c_ALU_SUB = 4'b0110,
    c_ALU_SLT = 4'b0111,
    c_ALU_NOR = 4'b1100
  } alu_op_e;

  // Operation class from main control.
  localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
  localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
  localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] c_ALUOP_NOR   = 2'b11;

  // funct[3:0] encodings honoured when the class is c_ALUOP_FUNCT.
  localparam logic [3:0] c_FUNCT_ADD = 4'b0000;
  localparam logic [3:0] c_FUNCT_SUB = 4'b0010;
  localparam logic [3:0] c_FUNCT_AND = 4'b0100;
  localparam logic [3:0] c_FUNCT_OR  = 4'b0101;
  localparam logic [3:0] c_FUNCT_XOR = 4'b0110;
  localparam logic [3:0] c_FUNCT_NOR = 4'b0111;
  localparam logic [3:0] c_FUNCT_SLT = 4'b1010;

endpackage : alu_datapath_pkg
`default_nettype wire

// File: rtl/alu_datapath_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_datapath_if
// Purpose  : Bundles the operand/control inputs and result/flag outputs of
//            the ALU datapath.
// Modports : master - drives aluop, funct, a, b, pc, imm_ext; observes results
//            slave  - the datapath: consumes operands, drives result, zero,
//                     alu_op, pc_plus4, branch_target, status_n/v/z
// Revision : 1.0 - initial release
// ============================================================================
interface alu_datapath_if #(
  parameter int DATA_W = 32
);
  logic [1:0]        aluop;
  logic [3:0]        funct;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] imm_ext;

  logic [DATA_W-1:0] result;
  logic              zero;
  logic [3:0]        alu_op;
  logic [DATA_W-1:0] pc_plus4;
  logic [DATA_W-1:0] branch_target;
  logic              status_n;
  logic              status_v;
  logic              status_z;

  modport master (
    output aluop, funct, a, b, pc, imm_ext,
    input  result, zero, alu_op, pc_plus4, branch_target,
           status_n, status_v, status_z
  );

  modport slave (
    input  aluop, funct, a, b, pc, imm_ext,
    output result, zero, alu_op, pc_plus4, branch_target,
           status_n, status_v, status_z
  );
endinterface : alu_datapath_if
`default_nettype wire

// File: rtl/alu_datapath_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl
// Purpose  : Combinational ALU control decode. Maps the main-control class
//            (and funct for R-type) onto a 4-bit ALU operation code.
// Ports    : aluop  in  2  operation class
//            funct  in  4  instruction bits [3:0]
//            alu_op out 4  decoded operation code
// Revision : 1.0 - initial release
// ============================================================================
module alu_ctrl
  import alu_datapath_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [3:0] funct,
  output logic [3:0] alu_op
);

  always_comb begin
    alu_op = c_ALU_ADD;
    case (aluop)
      c_ALUOP_ADD: alu_op = c_ALU_ADD;
      c_ALUOP_SUB: alu_op = c_ALU_SUB;
      c_ALUOP_NOR: alu_op = c_ALU_NOR;
      c_ALUOP_FUNCT: begin
        // Unlisted funct values fall back to ADD.
        case (funct)
          c_FUNCT_ADD: alu_op = c_ALU_ADD;
          c_FUNCT_SUB: alu_op = c_ALU_SUB;
          c_FUNCT_AND: alu_op = c_ALU_AND;
          c_FUNCT_OR:  alu_op = c_ALU_OR;
          c_FUNCT_XOR: alu_op = c_ALU_XOR;
          c_FUNCT_NOR: alu_op = c_ALU_NOR;
          c_FUNCT_SLT: alu_op = c_ALU_SLT;
          default:     alu_op = c_ALU_ADD;
        endcase
      end
      default: alu_op = c_ALU_ADD;
    endcase
  end

endmodule : alu_ctrl
`default_nettype wire

// File: rtl/alu_datapath.sv
`default_nettype none
// ============================================================================
// Module   : alu_datapath
// Purpose  : Single-cycle ALU datapath: ALU control decode, combinational
//            ALU with zero detect, PC incrementer and branch-target adder,
//            plus an optional one-cycle-lagging N/V/Z status register.
// Ports    : clk    in  1   clock (rising edge)
//            rst_n  in  1   synchronous active-low reset (status flags only)
//            bus    slave   alu_datapath_if (operands in, results/flags out)
// Config   : ALU_STATUS_FLAGS_EN - when defined, builds the status flag
//            register; when undefined, status_n/v/z are tied low and
//            clk/rst_n are not used.
// Revision : 1.0 - initial release
// ============================================================================
module alu_datapath
  import alu_datapath_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_INC = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_datapath_if.slave bus
);

  localparam logic [DATA_W-1:0] c_PC_INC = DATA_W'(PC_INC);
  localparam int                c_MSB    = DATA_W - 1;

  logic [3:0]        w_alu_op;
  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_diff;
  logic              w_lt;
  logic [DATA_W-1:0] w_result;
  logic              w_ovf;
  logic              w_zero;

  alu_ctrl u_alu_ctrl (
    .aluop  (bus.aluop),
    .funct  (bus.funct),
    .alu_op (w_alu_op)
  );

  assign w_sum  = bus.a + bus.b;
  assign w_diff = bus.a - bus.b;
  assign w_lt   = $signed(bus.a) < $signed(bus.b);

  always_comb begin
    w_result = '0;
    case (w_alu_op)
      c_ALU_AND: w_result = bus.a & bus.b;
      c_ALU_OR:  w_result = bus.a | bus.b;
      c_ALU_ADD: w_result = w_sum;
      c_ALU_XOR: w_result = bus.a ^ bus.b;
      c_ALU_SUB: w_result = w_diff;
      c_ALU_SLT: w_result = {{(DATA_W-1){1'b0}}, w_lt};
      c_ALU_NOR: w_result = ~(bus.a | bus.b);
      default:   w_result = '0;
    endcase
  end

  // Signed overflow only exists for ADD/SUB; every other op reports none.
  always_comb begin
    w_ovf = 1'b0;
    case (w_alu_op)
      c_ALU_ADD: w_ovf = (bus.a[c_MSB] == bus.b[c_MSB]) &&
                         (w_result[c_MSB] != bus.a[c_MSB]);
      c_ALU_SUB: w_ovf = (bus.a[c_MSB] != bus.b[c_MSB]) &&
                         (w_result[c_MSB] != bus.a[c_MSB]);
      default:   w_ovf = 1'b0;
    endcase
  end

  assign w_zero = (w_result == '0);

  assign bus.result        = w_result;
  assign bus.zero          = w_zero;
  assign bus.alu_op        = w_alu_op;
  assign bus.pc_plus4      = bus.pc + c_PC_INC;
  assign bus.branch_target = bus.pc_plus4 + (bus.imm_ext << 2);

`ifdef ALU_STATUS_FLAGS_EN
  logic r_status_n;
  logic r_status_v;
  logic r_status_z;

  // Flags capture the operation presented in the previous cycle; reset wins
  // over the capture in the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_status_n <= 1'b0;
      r_status_v <= 1'b0;
      r_status_z <= 1'b0;
    end else begin
      r_status_n <= w_result[c_MSB];
      r_status_v <= w_ovf;
      r_status_z <= w_zero;
    end
  end

  assign bus.status_n = r_status_n;
  assign bus.status_v = r_status_v;
  assign bus.status_z = r_status_z;
`else
  // No status register in this build: clock, reset and overflow are unused.
  logic w_unused_flag_inputs;
  assign w_unused_flag_inputs = clk ^ rst_n ^ w_ovf;

  assign bus.status_n = 1'b0;
  assign bus.status_v = 1'b0;
  assign bus.status_z = 1'b0;
`endif

endmodule : alu_datapath
`default_nettype wire

// File: tb/tb_alu_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_datapath
// Purpose  : Self-checking bench for alu_datapath. Directed vectors with
//            hand-computed results are applied one per cycle; expectations
//            go into a scoreboard queue that a negedge monitor drains.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_datapath;

  typedef struct {
    logic [31:0] result;
    logic        zero;
    logic [3:0]  alu_op;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic        st_n;
    logic        st_v;
    logic        st_z;
  } exp_t;

  logic clk;
  logic rst_n;

  exp_t sb[$];
  int   total;
  int   bad;

  // Flags the DUT should be showing during the next applied vector.
  logic prev_n;
  logic prev_v;
  logic prev_z;

  alu_datapath_if #(.DATA_W(32)) bus ();

  alu_datapath #(
    .DATA_W (32),
    .PC_INC (4)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Apply one vector for one cycle and queue what should be seen this cycle.
  task automatic run_vec(
    input logic        rst,
    input logic [1:0]  aluop,
    input logic [3:0]  funct,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] pc,
    input logic [31:0] imm,
    input logic [31:0] exp_res,
    input logic [3:0]  exp_op,
    input logic        exp_v,
    input logic [31:0] exp_pc4,
    input logic [31:0] exp_bt
  );
    exp_t e;
    @(posedge clk);
    #1;
    rst_n       = rst;
    bus.aluop   = aluop;
    bus.funct   = funct;
    bus.a       = a;
    bus.b       = b;
    bus.pc      = pc;
    bus.imm_ext = imm;
    e.result        = exp_res;
    e.zero          = (exp_res == 32'h0);
    e.alu_op        = exp_op;
    e.pc_plus4      = exp_pc4;
    e.branch_target = exp_bt;
`ifdef ALU_STATUS_FLAGS_EN
    e.st_n = prev_n;
    e.st_v = prev_v;
    e.st_z = prev_z;
    prev_n = rst & exp_res[31];
    prev_v = rst & exp_v;
    prev_z = rst & (exp_res == 32'h0);
`else
    e.st_n = 1'b0;
    e.st_v = 1'b0;
    e.st_z = 1'b0;
`endif
    sb.push_back(e);
  endtask

  // Monitor: the combinational outputs are valid every cycle, so compare
  // whenever an expectation is pending.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("result",        bus.result,               e.result);
      chk("zero",          {31'h0, bus.zero},        {31'h0, e.zero});
      chk("alu_op",        {28'h0, bus.alu_op},      {28'h0, e.alu_op});
      chk("pc_plus4",      bus.pc_plus4,             e.pc_plus4);
      chk("branch_target", bus.branch_target,        e.branch_target);
      chk("status_nvz",    {29'h0, bus.status_n, bus.status_v, bus.status_z},
                           {29'h0, e.st_n, e.st_v, e.st_z});
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    prev_n = 1'b0;
    prev_v = 1'b0;
    prev_z = 1'b0;
    rst_n       = 1'b0;
    bus.aluop   = 2'b00;
    bus.funct   = 4'h0;
    bus.a       = 32'h0;
    bus.b       = 32'h0;
    bus.pc      = 32'h0;
    bus.imm_ext = 32'h0;
    repeat (3) @(posedge clk);

    //       rst  aluop  funct   a             b             pc            imm           result        op     v     pc4           bt
    // Reset held: outputs still combinational, flags from prior reset.
    run_vec(1'b0, 2'b00, 4'h0, 32'h00000001, 32'h00000002, 32'h0000001C, 32'hFFFFFFFE, 32'h00000003, 4'h2, 1'b0, 32'h00000020, 32'h00000018);
    // R-type ADD with positive overflow; pc wraps.
    run_vec(1'b1, 2'b10, 4'h0, 32'h7FFFFFFF, 32'h00000001, 32'hFFFFFFFC, 32'h00000000, 32'h80000000, 4'h2, 1'b1, 32'h00000000, 32'h00000000);
    // SUB equal operands -> zero.
    run_vec(1'b1, 2'b01, 4'h0, 32'h00000005, 32'h00000005, 32'h00000100, 32'h00000001, 32'h00000000, 4'h6, 1'b0, 32'h00000104, 32'h00000108);
    // SLT signed: -1 < 1, then 1 < -1 false.
    run_vec(1'b1, 2'b10, 4'hA, 32'hFFFFFFFF, 32'h00000001, 32'h7FFFFFFC, 32'h00000010, 32'h00000001, 4'h7, 1'b0, 32'h80000000, 32'h80000040);
    run_vec(1'b1, 2'b10, 4'hA, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h00000000, 4'h7, 1'b0, 32'h00000004, 32'h00000004);
    // aluop NOR class.
    run_vec(1'b1, 2'b11, 4'h0, 32'h0000F0F0, 32'h00000F0F, 32'h00000000, 32'h00000000, 32'hFFFF0000, 4'hC, 1'b0, 32'h00000004, 32'h00000004);
    // Funct AND, OR, XOR, NOR.
    run_vec(1'b1, 2'b10, 4'h4, 32'hFF00FF00, 32'h0F0F0F0F, 32'h00000000, 32'h00000000, 32'h0F000F00, 4'h0, 1'b0, 32'h00000004, 32'h00000004);
    run_vec(1'b1, 2'b10, 4'h5, 32'hFF00FF00, 32'h0F0F0F0F, 32'h00000000, 32'h00000000, 32'hFF0FFF0F, 4'h1, 1'b0, 32'h00000004, 32'h00000004);
    run_vec(1'b1, 2'b10, 4'h6, 32'hFF00FF00, 32'h0F0F0F0F, 32'h00000000, 32'h00000000, 32'hF00FF00F, 4'h3, 1'b0, 32'h00000004, 32'h00000004);
    run_vec(1'b1, 2'b10, 4'h7, 32'hFF00FF00, 32'h0F0F0F0F, 32'h00000000, 32'h00000000, 32'h00F000F0, 4'hC, 1'b0, 32'h00000004, 32'h00000004);
    // Funct SUB with negative-minus-positive overflow.
    run_vec(1'b1, 2'b10, 4'h2, 32'h80000000, 32'h00000001, 32'h00000000, 32'h00000000, 32'h7FFFFFFF, 4'h6, 1'b1, 32'h00000004, 32'h00000004);
    // SUB positive-minus-negative overflow.
    run_vec(1'b1, 2'b01, 4'h0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h80000000, 4'h6, 1'b1, 32'h00000004, 32'h00000004);
    // Unlisted funct falls back to ADD.
    run_vec(1'b1, 2'b10, 4'hF, 32'h00000002, 32'h00000003, 32'h00000000, 32'h00000000, 32'h00000005, 4'h2, 1'b0, 32'h00000004, 32'h00000004);
    // ADD wrapping to zero without overflow.
    run_vec(1'b1, 2'b00, 4'h0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000000, 32'h00000000, 4'h2, 1'b0, 32'h00000004, 32'h00000004);
    // ADD negative overflow to zero.
    run_vec(1'b1, 2'b00, 4'h0, 32'h80000000, 32'h80000000, 32'h00000000, 32'h00000000, 32'h00000000, 4'h2, 1'b1, 32'h00000004, 32'h00000004);
    // Set N and V, then reset for one clock while inputs keep changing.
    run_vec(1'b1, 2'b10, 4'h0, 32'h7FFFFFFF, 32'h00000001, 32'h00000000, 32'h00000000, 32'h80000000, 4'h2, 1'b1, 32'h00000004, 32'h00000004);
    run_vec(1'b0, 2'b00, 4'h0, 32'h00000003, 32'h00000004, 32'h00000000, 32'h00000000, 32'h00000007, 4'h2, 1'b0, 32'h00000004, 32'h00000004);
    run_vec(1'b1, 2'b01, 4'h0, 32'h00000010, 32'h00000003, 32'h00000000, 32'h00000000, 32'h0000000D, 4'h6, 1'b0, 32'h00000004, 32'h00000004);
    run_vec(1'b1, 2'b00, 4'h0, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 4'h2, 1'b0, 32'h00000004, 32'h00000004);
    run_vec(1'b1, 2'b00, 4'h0, 32'h00000001, 32'h00000001, 32'h00000000, 32'h00000000, 32'h00000002, 4'h2, 1'b0, 32'h00000004, 32'h00000004);

    @(negedge clk);
    @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_alu_datapath
`default_nettype wire

// File: doc/alu_datapath.md
ALU_DATAPATH -- requirements
Module: alu_datapath

Interface
REQ-001 Parameter DATA_W, default 32, width of operands, result and addresses; only 32 is required to be supported.
REQ-002 Parameter PC_INC, default 4, constant added to pc by the incrementer.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset is synchronous and active-low.
REQ-005 aluop  input  2  ALU operation class from main control.
REQ-006 funct  input  4  instruction bits [3:0], used when aluop=10.
REQ-007 a  input  DATA_W  operand A (register rs).
REQ-008 b  input  DATA_W  operand B (register rt or extended immediate).
REQ-009 pc  input  DATA_W  current program counter.
REQ-010 imm_ext  input  DATA_W  sign-extended 16-bit immediate.
REQ-011 result  output  DATA_W  ALU result.
REQ-012 zero  output  1  combinational, high when result==0.
REQ-013 alu_op  output  4  decoded ALU operation code (gout).
REQ-014 pc_plus4  output  DATA_W  pc+PC_INC.
REQ-015 branch_target  output  DATA_W  pc_plus4 + (imm_ext<<2).
REQ-016 status_n, status_v, status_z  output  1 each  registered negative, overflow and zero flags.

Function
REQ-017 ALU control SHALL decode combinationally: aluop 00 -> ADD; 01 -> SUB; 11 -> NOR; 10 -> by funct.
REQ-018 funct decode: 0000 ADD, 0010 SUB, 0100 AND, 0101 OR, 0110 XOR, 0111 NOR, 1010 SLT; any other funct -> ADD.
REQ-019 alu_op codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0110, SLT 0111, NOR 1100; unknown alu_op internally -> result 0.
REQ-020 result SHALL be combinational in the same cycle: ADD a+b and SUB a-b, both modulo 2^32; AND, OR, XOR, NOR bitwise; SLT yields 1 if a<b signed, else 0.
REQ-021 Overflow (combinational): ADD when a[31]==b[31] and result[31]!=a[31]; SUB when a[31]!=b[31] and result[31]!=a[31]; 0 for all other ops.
REQ-022 On each rising clk with rst_n=1, status_n<=result[31], status_v<=overflow and status_z<=(result==0); flags reflect the previous cycle's operation, so they lag by one cycle.
REQ-023 pc_plus4 and branch_target SHALL be purely combinational and wrap modulo 2^32, with no flags.
REQ-024 zero output SHALL NOT be registered and SHALL be independent of status_z.

Reset
REQ-025 While rst_n=0 at a rising clk, status_n, status_v and status_z SHALL become 0; combinational outputs are unaffected by reset.
REQ-026 Reset asserted mid-operation SHALL override the flag update in that cycle.

Configuration
REQ-027 Macro ALU_STATUS_FLAGS_EN: when defined, the status register is implemented per REQ-022/025; when undefined, no flops are built, status_n/v/z are tied to 0, and clk/rst_n are unused.

Structure
REQ-028 Shared package alu_datapath_pkg SHALL hold the alu_op code constants, the aluop class encodings and the funct encodings.
REQ-029 ALU control decode SHALL be a sub-module named alu_ctrl, instantiated once; the adders and ALU stay inline.

Verification
REQ-030 aluop=10, funct=0000, a=0x7FFFFFFF, b=1 -> result 0x80000000, alu_op 0010; after the next clk, status_n=1, status_v=1, status_z=0.
REQ-031 aluop=01, a=5, b=5 -> result 0 and zero=1; after clk, status_z=1, status_v=0.
REQ-032 aluop=10, funct=1010, a=0xFFFFFFFF, b=1 -> result 1; with a=1 and b=0xFFFFFFFF -> result 0.
REQ-033 aluop=11, a=0x0000F0F0, b=0x00000F0F -> result 0xFFFF0000, alu_op 1100.
REQ-034 pc=0x1C, imm_ext=0xFFFFFFFE -> pc_plus4 0x20, branch_target 0x18; pc=0xFFFFFFFC -> pc_plus4 0.
REQ-035 Drive flags to 1 and then hold rst_n=0 for one clk -> all status flags read 0 while result still tracks its inputs.
